// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard controller for a five-stage in-order core. It resolves
//   load-use, taken-branch and data-memory-wait hazards and steers the
//   stall and flush controls of the pipeline registers. A small FSM watches
//   data-memory waits. When a wait runs MEM_TIMEOUT cycles without an ack,
//   the FSM enters a terminal FAULT state that only reset can clear.
//
// Ports
//   CLK, RST_N            clock, asynchronous active-low reset
//   rs1_D, rs2_D          source registers of the instruction in Decode
//   rd_E, memRead_E       destination register / load flag in Execute
//   branchTaken_E         taken branch or jump resolved in Execute
//   mem_req_M, mem_ack_M  outstanding data access / completion in Memory
//   stall_F..stall_M      hold PC, IF-ID, ID-EX, EX-MEM registers
//   flush_D, flush_E      bubble IF-ID, ID-EX registers
//   state                 RUN=00, MEM_WAIT=01, FAULT=10
//   mem_fault             sticky memory-timeout flag
//   stall_cycles          saturating count of cycles with stall_F=1
//   flush_count           saturating count of cycles with any flush
module hazard_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic [4:0]  rd_E,
  input  logic        memRead_E,
  input  logic        branchTaken_E,
  input  logic        mem_req_M,
  input  logic        mem_ack_M,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        stall_M,
  output logic        flush_D,
  output logic        flush_E,
  output logic [1:0]  state,
  output logic        mem_fault,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } state_t;

  localparam logic [16:0] TIMEOUT_W = 17'(MEM_TIMEOUT);

  state_t      state_reg;
  logic [15:0] wait_cnt_reg;
  logic        mem_fault_reg;
  logic [15:0] stall_cycles_reg;
  logic [15:0] flush_count_reg;

  logic mem_wait;
  logic load_use;

  assign mem_wait = mem_req_M && !mem_ack_M;
  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign load_use = memRead_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));

  // Hazard steering, highest priority first: fault, memory wait, branch, load-use.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if ((state_reg == FAULT) || mem_wait) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
    end else if (branchTaken_E) begin
      // The redirect kills both younger instructions, so a load-use stall is moot.
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (load_use) begin
      // Hold Fetch/Decode and insert a bubble into Execute for one cycle.
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  // Memory-wait FSM with wait counter and sticky fault flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= 16'd0;
      mem_fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (mem_wait) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= 16'd1;
          end
        end
        MEM_WAIT: begin
          // A dropped request is treated the same as a completed one.
          if (!mem_req_M || mem_ack_M) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 16'd0;
          end else begin
            // Fault on the edge where the count of wait cycles reaches the limit.
            if (({1'b0, wait_cnt_reg} + 17'd1) >= TIMEOUT_W) begin
              state_reg     <= FAULT;
              mem_fault_reg <= 1'b1;
            end
            if (wait_cnt_reg != 16'hFFFF) begin
              wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end
          end
        end
        FAULT: begin
          state_reg <= FAULT;
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= 16'd0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cycles_reg <= 16'd0;
      flush_count_reg  <= 16'd0;
    end else begin
      if (stall_F && (stall_cycles_reg != 16'hFFFF)) begin
        stall_cycles_reg <= stall_cycles_reg + 16'd1;
      end
      if ((flush_D || flush_E) && (flush_count_reg != 16'hFFFF)) begin
        flush_count_reg <= flush_count_reg + 16'd1;
      end
    end
  end

  assign state        = state_reg;
  assign mem_fault    = mem_fault_reg;
  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
//   Directed and randomized stimulus for hazard_control_unit (MEM_TIMEOUT=4),
//   checked every cycle against a behavioural model of the hazard rules.
module tb_hazard_control_unit;

  localparam int TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [4:0]  rs1_D, rs2_D, rd_E;
  logic        memRead_E, branchTaken_E, mem_req_M, mem_ack_M;
  logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
  logic [1:0]  state;
  logic        mem_fault;
  logic [15:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  // Model state: mode 0=running, 1=waiting on memory, 2=faulted.
  int m_mode, m_waits, m_sc, m_fc;
  bit m_fault;

  hazard_control_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_E(rd_E),
    .memRead_E(memRead_E), .branchTaken_E(branchTaken_E),
    .mem_req_M(mem_req_M), .mem_ack_M(mem_ack_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E),
    .state(state), .mem_fault(mem_fault),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E} from the rules.
  function automatic logic [5:0] exp_hazard();
    bit waiting = mem_req_M && !mem_ack_M;
    bit dep = memRead_E && (rd_E != 0) && (rd_E == rs1_D || rd_E == rs2_D);
    if (m_mode == 2 || waiting) return 6'b111100;
    if (branchTaken_E)          return 6'b000011;
    if (dep)                    return 6'b110001;
    return 6'b000000;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".hazard"}, {26'd0, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E},
        {26'd0, exp_hazard()});
    chk({tag, ".state"}, {30'd0, state}, m_mode);
    chk({tag, ".fault"}, {31'd0, mem_fault}, {31'd0, m_fault});
    chk({tag, ".stall_cycles"}, {16'd0, stall_cycles}, m_sc);
    chk({tag, ".flush_count"}, {16'd0, flush_count}, m_fc);
  endtask

  task automatic model_reset();
    m_mode = 0; m_waits = 0; m_fault = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_edge();
    logic [5:0] h = exp_hazard();
    if (h[5] && m_sc < 65535) m_sc++;
    if ((h[1] || h[0]) && m_fc < 65535) m_fc++;
    if (m_mode == 0) begin
      if (mem_req_M && !mem_ack_M) begin m_mode = 1; m_waits = 1; end
    end else if (m_mode == 1) begin
      if (!mem_req_M || mem_ack_M) begin
        m_mode = 0; m_waits = 0;
      end else begin
        m_waits++;
        if (m_waits >= TIMEOUT) begin m_mode = 2; m_fault = 1; end
      end
    end
  endtask

  task automatic set_in(input bit mr, input int rd, input int r1, input int r2,
                        input bit br, input bit rq, input bit ak);
    memRead_E = mr; rd_E = 5'(rd); rs1_D = 5'(r1); rs2_D = 5'(r2);
    branchTaken_E = br; mem_req_M = rq; mem_ack_M = ak;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock cycle: check before the edge, advance the model on the edge.
  task automatic cycle(input string tag);
    #3;
    check_all(tag);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic async_reset(input string tag);
    idle();
    #1;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    idle();
    model_reset();
    #2;
    check_all("reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Load-use on rs2 for exactly one cycle.
    set_in(1, 5, 0, 5, 0, 0, 0);
    cycle("load_use");
    idle();
    cycle("load_use_after");
    chk("load_use_stall_cycles", {16'd0, stall_cycles}, 32'd1);

    // Load-use on rs1.
    set_in(1, 7, 7, 3, 0, 0, 0);
    cycle("load_use_rs1");

    // Branch together with a load-use: the branch wins.
    async_reset("reset2");
    set_in(1, 5, 0, 5, 1, 0, 0);
    cycle("branch_vs_lu");
    idle();
    cycle("branch_after");
    chk("branch_flush_count", {16'd0, flush_count}, 32'd1);

    // x0 never causes a stall.
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle("x0");

    // Memory wait of three cycles, ack on the fourth (boundary: no fault).
    async_reset("reset3");
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0);
      cycle("mem_wait");
    end
    chk("mem_wait_state", {30'd0, state}, 32'd1);
    set_in(0, 0, 0, 0, 0, 1, 1);
    cycle("mem_ack");
    idle();
    cycle("mem_done");
    chk("mem_done_state", {30'd0, state}, 32'd0);
    chk("mem_stall_cycles", {16'd0, stall_cycles}, 32'd3);

    // Dropped request while waiting returns to RUN.
    set_in(0, 0, 0, 0, 1, 1, 0);
    cycle("drop_wait");
    set_in(0, 0, 0, 0, 1, 0, 0);
    cycle("drop_req");
    idle();
    cycle("drop_idle");

    // Timeout: four wait cycles without ack.
    for (int i = 0; i < TIMEOUT; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0);
      cycle("timeout_wait");
    end
    chk("timeout_state", {30'd0, state}, 32'd2);
    chk("timeout_fault", {31'd0, mem_fault}, 32'd1);
    set_in(1, 5, 5, 0, 1, 0, 1);
    cycle("fault_holds");
    idle();
    cycle("fault_idle");
    async_reset("fault_reset");
    chk("fault_reset_state", {30'd0, state}, 32'd0);
    cycle("post_reset_idle");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 5) == 0,
             $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0);
      cycle("random");
      if (m_mode == 2 && $urandom_range(0, 3) == 0) async_reset("random_reset");
    end

    // Saturation: hold a load-use so both counters run into 16'hFFFF.
    async_reset("sat_reset");
    set_in(1, 5, 0, 5, 0, 0, 0);
    for (int i = 0; i < 65540; i++) cycle("saturate");
    chk("sat_stall_cycles", {16'd0, stall_cycles}, 32'hFFFF);
    chk("sat_flush_count", {16'd0, flush_count}, 32'hFFFF);
    idle();
    cycle("sat_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
